// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for RV32M DIV/DIVU/REM/REMU
// One quotient bit per CALC cycle; divide-by-zero and signed overflow finish directly.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] res_r;
  logic             sel_rem, neg_q, neg_r;

  logic             accept, is_signed, a_neg, b_neg, div_zero, ovf, fast, take, last;
  logic [WIDTH-1:0] a_mag, b_mag, fast_res, prem_nxt, quo_nxt, fin_q, fin_r;
  logic [WIDTH:0]   shifted, diff;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_r;
  assign accept    = in_valid && in_ready && !flush;

  assign is_signed = !op[0];
  assign a_neg     = is_signed && dividend[WIDTH-1];
  assign b_neg     = is_signed && divisor[WIDTH-1];
  assign a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero  = (divisor == '0);
  assign ovf       = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
  assign fast      = div_zero || ovf;

  // On overflow the quotient equals the dividend (most negative value) and the remainder is zero.
  always_comb begin
    fast_res = '0;
    if (div_zero) fast_res = op[1] ? dividend : '1;
    else          fast_res = op[1] ? '0 : dividend;
  end

  // Borrow lives in bit WIDTH of the difference; a clear borrow means the subtraction fits.
  assign shifted  = {prem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvsr};
  assign take     = !diff[WIDTH];
  assign prem_nxt = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nxt  = {quo[WIDTH-2:0], take};
  assign last     = (cnt == CW'(1));
  assign fin_q    = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
  assign fin_r    = neg_r ? (~prem_nxt + 1'b1) : prem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      prem    <= '0;
      quo     <= '0;
      dvsr    <= '0;
      res_r   <= '0;
      sel_rem <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        cnt     <= CW'(WIDTH);
        prem    <= '0;
        quo     <= a_mag;
        dvsr    <= b_mag;
        sel_rem <= op[1];
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
        if (fast) res_r <= fast_res;
      end else if (state == CALC) begin
        cnt  <= cnt - CW'(1);
        prem <= prem_nxt;
        quo  <= quo_nxt;
        if (last) res_r <= sel_rem ? fin_r : fin_q;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
// Driver pushes expected results; a negedge monitor pops and compares on each response.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] dividend, divisor, result;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b1;
  bit   seen = 1'b0;
  bit   chk_after = 1'b0;

  localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (chk_after) begin
        check("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
        check("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
        chk_after = 1'b0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          if (!seen) begin
            seen = 1'b1;
            check("latency", 32'(cyc - sb[0].n), 32'(sb[0].lat));
          end
          check("result", result, sb[0].res);
          check("in_ready_while_valid", {31'd0, in_ready}, 32'd0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
            chk_after = 1'b1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit track);
    int guard = 0;
    exp_t e;
    op = o; dividend = a; divisor = b; in_valid = 1'b1;
    while (!in_ready && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) check("issue_timeout", 32'd1, 32'd0);
    e.res = exp; e.lat = lat; e.n = cyc;
    if (track) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 2'($urandom); dividend = $urandom; divisor = $urandom;
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || !in_ready) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);           drain();
    issue(REMU, 32'd100, 32'd7, 32'd2, 33, 1'b1);            drain();
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1); drain();
    issue(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1); drain();
    issue(REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b1);       drain();
    issue(DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b1); drain();
    issue(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);       drain();
    issue(REM, 32'h1234, 32'd0, 32'h1234, 1, 1'b1);          drain();
    issue(DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 1, 1'b1); drain();
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1); drain();
    issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);  drain();
    issue(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b1); drain();
    issue(REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, 1'b1);     drain();
    issue(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1); drain();

    // Backpressure: hold the result for ten cycles.
    out_ready = 1'b0;
    issue(DIVU, 32'd1000, 32'd10, 32'd100, 33, 1'b1);
    begin
      int guard = 0;
      while (!out_valid && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) check("bp_valid_timeout", 32'd1, 32'd0);
    end
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Flush during CALC; in_valid is also held high on the flush cycle.
    issue(DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1; in_valid = 1'b1; op = DIVU; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    issue(REMU, 32'd1001, 32'd10, 32'd1, 33, 1'b1);          drain();

    // Reset during CALC.
    issue(DIV, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("rst_calc_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_calc_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_release_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Reset while holding a result drops out_valid without a clock edge.
    mon_en = 1'b0;
    out_ready = 1'b0;
    issue(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    @(negedge clk);
    check("done_out_valid", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_done_async_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;
    issue(DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b1); drain();
    issue(REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 1'b1); drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
